// File: rtl/stream_arith_pkg.sv
// stream_arith_pkg: op encodings, FSM states and clamp helpers for stream_arith
package stream_arith_pkg;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_MAX = 2'd3;
  typedef enum logic [1:0] {COLLECT, COMPUTE, OUTPUT} state_t;
  function automatic logic [63:0] sat_max(input int bits);
    return (64'd1 << (bits - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int bits);
    return ~sat_max(bits);
  endfunction
endpackage

// File: rtl/stream_arith_mul.sv
// stream_arith_mul: sequential signed shift-add multiplier, done BITS cycles after start
module stream_arith_mul #(
  parameter int BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BITS-1:0]     a,
  input  logic [BITS-1:0]     b,
  output logic                done,
  output logic [2*BITS-1:0]   product
);
  localparam int CW = $clog2(BITS);
  logic [2*BITS-1:0] mcand, acc, acc_nx;
  logic [BITS-1:0] mplier, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic busy, neg;
  assign mag_a = a[BITS-1] ? -a : a;
  assign mag_b = b[BITS-1] ? -b : b;
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  assign done = busy && cnt == CW'(BITS - 1);
  assign product = neg ? -acc_nx : acc_nx;
  // load magnitudes on start, then one multiplier bit per cycle; the last bit is folded into product
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
      neg <= 1'b0;
    end else if (start) begin
      mcand <= {{BITS{1'b0}}, mag_a};
      mplier <= mag_b;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b1;
      neg <= a[BITS-1] ^ b[BITS-1];
    end else if (busy) begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/stream_arith.sv
// stream_arith: stb/ack add/sub/mul/max node with overflow flag; STREAM_ARITH_SAT_EN selects saturation over wrap
module stream_arith
  import stream_arith_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] in1,
  input  logic            in1_stb,
  output logic            in1_ack,
  input  logic [BITS-1:0] in2,
  input  logic            in2_stb,
  output logic            in2_ack,
  input  logic [1:0]      mode,
  output logic [BITS-1:0] out1,
  output logic            out1_stb,
  input  logic            out1_ack,
  output logic            ovf
);
  state_t state;
  logic have1, have2, t1, t2, complete, mul_done, ovf_c, ready;
  logic [1:0] op;
  logic [BITS-1:0] a, b, mx, res_out;
  logic [BITS:0] addsub;
  logic [2*BITS-1:0] mul_prod, res;
  logic [BITS:0] hi;
  assign in1_ack = !rst && state == COLLECT && !have1;
  assign in2_ack = !rst && state == COLLECT && !have2;
  assign t1 = in1_stb && in1_ack;
  assign t2 = in2_stb && in2_ack;
  assign complete = (have1 || t1) && (have2 || t2) && (t1 || t2);
  stream_arith_mul #(.BITS(BITS)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(complete && mode == OP_MUL),
    .a(have1 ? a : in1),
    .b(have2 ? b : in2),
    .done(mul_done),
    .product(mul_prod)
  );
`ifdef STREAM_ARITH_SAT_EN
  localparam logic [BITS-1:0] SAT_MAX = BITS'(sat_max(BITS));
  localparam logic [BITS-1:0] SAT_MIN = BITS'(sat_min(BITS));
`endif
  // widen every op to 2*BITS so one range test covers add, sub and mul
  always_comb begin
    addsub = op == OP_SUB ? {a[BITS-1], a} - {b[BITS-1], b} : {a[BITS-1], a} + {b[BITS-1], b};
    mx = $signed(a) > $signed(b) ? a : b;
    res = op == OP_MUL ? mul_prod : op == OP_MAX ? {{BITS{mx[BITS-1]}}, mx} : {{(BITS-1){addsub[BITS]}}, addsub};
    hi = res[2*BITS-1:BITS-1];
    ovf_c = !(&hi || ~|hi);
`ifdef STREAM_ARITH_SAT_EN
    res_out = ovf_c ? (res[2*BITS-1] ? SAT_MIN : SAT_MAX) : res[BITS-1:0];
`else
    res_out = res[BITS-1:0];
`endif
    ready = op != OP_MUL || mul_done;
  end
  // collect operands, wait for the result, hold it until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      have1 <= 1'b0;
      have2 <= 1'b0;
      a <= '0;
      b <= '0;
      op <= OP_ADD;
      out1 <= '0;
      out1_stb <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (t1) begin
            a <= in1;
            have1 <= 1'b1;
          end
          if (t2) begin
            b <= in2;
            have2 <= 1'b1;
          end
          if (complete) begin
            op <= mode;
            state <= COMPUTE;
          end
        end
        COMPUTE: if (ready) begin
          out1 <= res_out;
          ovf <= ovf_c;
          out1_stb <= 1'b1;
          state <= OUTPUT;
        end
        default: if (out1_ack) begin
          out1_stb <= 1'b0;
          have1 <= 1'b0;
          have2 <= 1'b0;
          state <= COLLECT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stream_arith.sv
// tb_stream_arith: vector table, corner sequences and random transactions against an integer model
module tb_stream_arith;
  logic clk = 0, rst = 1;
  logic [15:0] in1 = 0, in2 = 0, out1;
  logic in1_stb = 0, in2_stb = 0, in1_ack, in2_ack, out1_stb, out1_ack = 0, ovf;
  logic [1:0] mode = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  stream_arith #(.BITS(16)) dut (
    .clk(clk), .rst(rst),
    .in1(in1), .in1_stb(in1_stb), .in1_ack(in1_ack),
    .in2(in2), .in2_stb(in2_stb), .in2_ack(in2_ack),
    .mode(mode),
    .out1(out1), .out1_stb(out1_stb), .out1_ack(out1_ack),
    .ovf(ovf)
  );
  typedef struct {
    logic [15:0] a, b;
    logic [1:0] m;
    int d1, d2, hold;
    logic [15:0] eo;
    logic ev;
    int el;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m, output logic [15:0] r, output logic o);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t = m == 0 ? sa + sb : m == 1 ? sa - sb : m == 2 ? sa * sb : (sa > sb ? sa : sb);
    o = t > 32767 || t < -32768;
`ifdef STREAM_ARITH_SAT_EN
    r = t > 32767 ? 16'h7FFF : t < -32768 ? 16'h8000 : 16'(t);
`else
    r = 16'(t);
`endif
  endtask
  task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m, input int d1, input int d2, input int hold,
                     output logic [15:0] r, output logic o, output int lat, output logic viol, output logic tout);
    int cyc;
    logic g1, g2, x1, x2;
    cyc = 0; g1 = 0; g2 = 0; viol = 0; tout = 0;
    while (!(g1 && g2) && cyc < 100) begin
      in1 = a; in2 = b; mode = m;
      in1_stb = !g1 && cyc >= d1;
      in2_stb = !g2 && cyc >= d2;
      @(negedge clk);
      if ((g1 && in1_ack) || (g2 && in2_ack)) viol = 1;
      x1 = in1_stb && in1_ack;
      x2 = in2_stb && in2_ack;
      @(posedge clk); #1;
      g1 |= x1; g2 |= x2; cyc++;
    end
    in1_stb = 0; in2_stb = 0;
    mode = 2'($urandom); in1 = 16'($urandom); in2 = 16'($urandom);
    if (!(g1 && g2)) tout = 1;
    lat = 0;
    while (!out1_stb && lat < 100) begin
      if (in1_ack || in2_ack) viol = 1;
      @(posedge clk); #1; lat++;
    end
    if (!out1_stb) tout = 1;
    r = out1; o = ovf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out1 !== r || ovf !== o || !out1_stb || in1_ack || in2_ack) viol = 1;
    end
    out1_ack = 1;
    @(posedge clk); #1;
    out1_ack = 0;
    if (out1_stb || !in1_ack || !in2_ack) viol = 1;
  endtask
  initial begin
    vec_t v[$];
    logic [15:0] r, er;
    logic o, eo, viol, tout, seen;
    int lat;
    v.push_back('{16'd3, 16'd4, 2'd0, 0, 0, 0, 16'd7, 1'b0, 1});
`ifdef STREAM_ARITH_SAT_EN
    v.push_back('{16'h8000, 16'd1, 2'd1, 0, 5, 0, 16'h8000, 1'b1, 1});
    v.push_back('{16'hFED4, 16'd200, 2'd2, 0, 0, 0, 16'h8000, 1'b1, 16});
    v.push_back('{16'h7FFF, 16'd1, 2'd0, 1, 0, 0, 16'h7FFF, 1'b1, 1});
    v.push_back('{16'h8000, 16'h8000, 2'd2, 0, 2, 0, 16'h7FFF, 1'b1, 16});
`else
    v.push_back('{16'h8000, 16'd1, 2'd1, 0, 5, 0, 16'h7FFF, 1'b1, 1});
    v.push_back('{16'hFED4, 16'd200, 2'd2, 0, 0, 0, 16'h15A0, 1'b1, 16});
    v.push_back('{16'h7FFF, 16'd1, 2'd0, 1, 0, 0, 16'h8000, 1'b1, 1});
    v.push_back('{16'h8000, 16'h8000, 2'd2, 0, 2, 0, 16'h0000, 1'b1, 16});
`endif
    v.push_back('{16'd7, 16'hFFFA, 2'd2, 0, 0, 0, 16'hFFD6, 1'b0, 16});
    v.push_back('{16'hFFFB, 16'd3, 2'd3, 0, 0, 10, 16'd3, 1'b0, 1});
    v.push_back('{16'h8000, 16'd1, 2'd2, 0, 0, 0, 16'h8000, 1'b0, 16});
    v.push_back('{16'd10, 16'd20, 2'd1, 3, 0, 0, 16'hFFF6, 1'b0, 1});
    v.push_back('{16'h8000, 16'h7FFF, 2'd3, 0, 0, 0, 16'h7FFF, 1'b0, 1});
    @(posedge clk); #1;
    chk("reset out1", out1, 0);
    chk("reset out1_stb", out1_stb, 0);
    chk("reset ovf", ovf, 0);
    chk("reset acks", {in1_ack, in2_ack}, 0);
    rst = 0;
    @(posedge clk); #1;
    foreach (v[i]) begin
      txn(v[i].a, v[i].b, v[i].m, v[i].d1, v[i].d2, v[i].hold, r, o, lat, viol, tout);
      chk($sformatf("vec%0d out1", i), r, v[i].eo);
      chk($sformatf("vec%0d ovf", i), o, v[i].ev);
      chk($sformatf("vec%0d latency", i), lat, v[i].el);
      chk($sformatf("vec%0d handshake", i), {viol, tout}, 0);
    end
    in1 = 16'd7; in2 = 16'd6; mode = 2'd2; in1_stb = 1; in2_stb = 1;
    @(posedge clk); #1;
    in1_stb = 0; in2_stb = 0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    chk("midreset out1_stb", out1_stb, 0);
    chk("midreset acks", {in1_ack, in2_ack}, 0);
    rst = 0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; seen |= out1_stb; end
    chk("midreset no stale result", seen, 0);
    txn(16'd1, 16'd1, 2'd0, 0, 0, 0, r, o, lat, viol, tout);
    chk("post reset add out1", r, 2);
    chk("post reset add ovf", o, 0);
    chk("post reset handshake", {viol, tout}, 0);
    for (int k = 0; k < 150; k++) begin
      logic [15:0] ra, rb;
      logic [1:0] rm;
      ra = 16'($urandom);
      rb = k % 4 == 0 ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rm = 2'($urandom);
      model(ra, rb, rm, er, eo);
      txn(ra, rb, rm, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, o, lat, viol, tout);
      chk($sformatf("rnd%0d out1 a=%0h b=%0h m=%0d", k, ra, rb, rm), r, er);
      chk($sformatf("rnd%0d ovf", k), o, eo);
      chk($sformatf("rnd%0d latency", k), lat, rm == 2 ? 16 : 1);
      chk($sformatf("rnd%0d handshake", k), {viol, tout}, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
